// File: rtl/arbitro_mem_dados_pkg.sv
// Shared encodings for the data-RAM arbiter:
// FSM states and requester port ids.
package pkg_mem;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    ACESSO   = 2'd1,
    RESPOSTA = 2'd2
  } estado_t;

  localparam logic PORTA_CPU   = 1'b0;
  localparam logic PORTA_CARGA = 1'b1;

endpackage

// File: rtl/arbitro_rr2.sv
// Two-way round-robin winner select.
// On conflict the port that did not win last time gets the grant.
module arbitro_rr2
  import pkg_mem::*;
(
  input  logic req0,
  input  logic req1,
  input  logic ultimo,
  output logic vencedor,
  output logic conflito
);

  always_comb begin
    conflito = req0 & req1;
    vencedor = PORTA_CPU;
    unique case (1'b1)
      conflito:      vencedor = ~ultimo;
      req1 & ~req0:  vencedor = PORTA_CARGA;
      default:       vencedor = PORTA_CPU;
    endcase
  end

endmodule

// File: rtl/arbitro_mem_dados.sv
// Arbiter and sequencer for the single-port data RAM.
// CPU (port 0) and loader (port 1) share it, 3 cycles per access.
module arbitro_mem_dados
  import pkg_mem::*;
#(
  parameter int LARGURA_END  = 32,
  parameter int LARGURA_DADO = 32,
  parameter int LARGURA_CONT = 16
) (
  input  logic                    clock,
  input  logic                    reiniciar,
  input  logic                    req0,
  input  logic                    we0,
  input  logic [LARGURA_END-1:0]  end0,
  input  logic [LARGURA_DADO-1:0] dado0,
  output logic                    ack0,
  input  logic                    req1,
  input  logic                    we1,
  input  logic [LARGURA_END-1:0]  end1,
  input  logic [LARGURA_DADO-1:0] dado1,
  output logic                    ack1,
  output logic [LARGURA_DADO-1:0] dado_lido,
  output logic                    mem_we,
  output logic [LARGURA_END-1:0]  mem_end,
  output logic [LARGURA_DADO-1:0] mem_dado,
  input  logic [LARGURA_DADO-1:0] mem_leitura,
  output logic                    ocupado,
  output logic [LARGURA_CONT-1:0] conflitos
);

  estado_t estado, prox;

  logic                    ultimo;
  logic                    lat_id;
  logic                    lat_we;
  logic [LARGURA_END-1:0]  lat_end;
  logic [LARGURA_DADO-1:0] lat_dado;
  logic                    vencedor;
  logic                    conflito;
  logic                    algum;

  assign algum = req0 | req1;

  arbitro_rr2 u_rr (
    .req0     (req0),
    .req1     (req1),
    .ultimo   (ultimo),
    .vencedor (vencedor),
    .conflito (conflito)
  );

  always_ff @(posedge clock) begin
    if (reiniciar) estado <= OCIOSO;
    else           estado <= prox;
  end

  always_comb begin
    prox = estado;
    unique case (estado)
      OCIOSO:   if (algum) prox = ACESSO;
      ACESSO:   prox = RESPOSTA;
      RESPOSTA: prox = OCIOSO;
      default:  prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reiniciar) begin
      ultimo    <= PORTA_CARGA;
      lat_id    <= PORTA_CPU;
      lat_we    <= 1'b0;
      lat_end   <= '0;
      lat_dado  <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      dado_lido <= '0;
      conflitos <= '0;
    end else begin
      unique case (estado)
        OCIOSO: begin
          if (algum) begin
            lat_id   <= vencedor;
            ultimo   <= vencedor;
            lat_we   <= vencedor ? we1   : we0;
            lat_end  <= vencedor ? end1  : end0;
            lat_dado <= vencedor ? dado1 : dado0;
          end
          if (conflito && !(&conflitos))
            conflitos <= conflitos + 1'b1;
        end
        ACESSO: begin
          dado_lido <= mem_leitura;
          ack0      <= (lat_id == PORTA_CPU);
          ack1      <= (lat_id == PORTA_CARGA);
        end
        RESPOSTA: begin
          ack0 <= 1'b0;
          ack1 <= 1'b0;
        end
        default: begin
          ack0 <= 1'b0;
          ack1 <= 1'b0;
        end
      endcase
    end
  end

  // Address/data stay parked on the latches so the RAM never sees glitches
  assign mem_we   = (estado == ACESSO) & lat_we & ~reiniciar;
  assign mem_end  = lat_end;
  assign mem_dado = lat_dado;
  assign ocupado  = (estado != OCIOSO);

endmodule
